// File: rtl/ethcrc_pkg.sv
// Shared Ethernet CRC-32 constants and the bytewise reflected CRC update.
// Used by both the RX FCS checker and the TX FCS appender.
package ethcrc_pkg;

   localparam logic [31:0] CRC_TAPS    = 32'hedb88320;
   localparam logic [31:0] CRC_INIT    = 32'hffffffff;
   localparam logic [31:0] CRC_RESIDUE = 32'hdebb20e3;

   // LSB-first update of a non-inverted CRC register by one byte.
   function automatic logic [31:0] next_crc(input logic [31:0] crc, input logic [7:0] d);
      logic [31:0] c;
      c = crc ^ {24'h000000, d};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ CRC_TAPS) : (c >> 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/crc32_byte.sv
// Combinational one-byte CRC-32 (reflected) update stage.
module crc32_byte
   import ethcrc_pkg::*;
(
   input  logic [31:0] crc_in,
   input  logic [7:0]  d,
   output logic [31:0] crc_out
);

   always_comb begin
      crc_out = next_crc(crc_in, d);
   end

endmodule

// File: rtl/rxecrc.sv
// RX Ethernet FCS checker: strips the trailing 4-byte FCS and flags bad CRC at frame end.
// Optional RXECRC_ERRCOUNT_EN adds a saturating bad-frame counter on o_err_count.
module rxecrc
   import ethcrc_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_ce,
   input  logic        i_en,
   input  logic        i_v,
   input  logic [7:0]  i_d,
   output logic        o_v,
   output logic [7:0]  o_d,
   output logic        o_err,
`ifdef RXECRC_ERRCOUNT_EN
   output logic [31:0] o_err_count,
`endif
   output logic        o_done
);

   logic [31:0]     crc_q, crc_d, crc_next;
   logic [2:0]      cnt_q, cnt_d;
   logic [3:0][7:0] buf_q, buf_d;
   logic            en_q, en_d, en_eff;
   logic            v_q, v_d;
   logic [7:0]      d_q, d_d;
   logic            err_q, err_d;
   logic            done_q, done_d;
   logic [31:0]     errcnt_q, errcnt_d;

   crc32_byte u_crc32_byte (
      .crc_in  (crc_q),
      .d       (i_d),
      .crc_out (crc_next)
   );

   always_comb begin
      crc_d    = crc_q;
      cnt_d    = cnt_q;
      buf_d    = buf_q;
      en_d     = en_q;
      v_d      = v_q;
      d_d      = d_q;
      err_d    = err_q;
      done_d   = done_q;
      errcnt_d = errcnt_q;
      en_eff   = en_q;
      if (i_ce) begin
         if (i_v) begin
            // Mode is sampled on the first byte and held for the rest of the frame.
            en_eff = (cnt_q == 3'd0) ? i_en : en_q;
            en_d   = en_eff;
            done_d = 1'b0;
            cnt_d  = (cnt_q == 3'd4) ? 3'd4 : cnt_q + 3'd1;
            if (en_eff) begin
               buf_d = {buf_q[2:0], i_d};
               crc_d = crc_next;
               v_d   = (cnt_q == 3'd4);
               if (cnt_q == 3'd4) begin
                  d_d = buf_q[3];
               end
            end else begin
               v_d = 1'b1;
               d_d = i_d;
            end
         end else if (cnt_q != 3'd0) begin
            v_d    = 1'b0;
            done_d = 1'b1;
            err_d  = en_q && ((cnt_q < 3'd4) || (crc_q != CRC_RESIDUE));
            crc_d  = CRC_INIT;
            cnt_d  = 3'd0;
            if (err_d && (errcnt_q != 32'hffffffff)) begin
               errcnt_d = errcnt_q + 32'd1;
            end
         end else begin
            v_d    = 1'b0;
            done_d = 1'b0;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         crc_q    <= CRC_INIT;
         cnt_q    <= 3'd0;
         buf_q    <= '0;
         en_q     <= 1'b1;
         v_q      <= 1'b0;
         d_q      <= 8'h00;
         err_q    <= 1'b0;
         done_q   <= 1'b0;
         errcnt_q <= 32'd0;
      end else begin
         crc_q    <= crc_d;
         cnt_q    <= cnt_d;
         buf_q    <= buf_d;
         en_q     <= en_d;
         v_q      <= v_d;
         d_q      <= d_d;
         err_q    <= err_d;
         done_q   <= done_d;
         errcnt_q <= errcnt_d;
      end
   end

   assign o_v    = v_q;
   assign o_d    = d_q;
   assign o_err  = err_q;
   assign o_done = done_q;
`ifdef RXECRC_ERRCOUNT_EN
   assign o_err_count = errcnt_q;
`else
   logic unused_errcnt;
   assign unused_errcnt = ^errcnt_q;
`endif

endmodule

// File: tb/tb_rxecrc.sv
// Directed self-checking bench for rxecrc (FCS strip/check, passthrough, i_ce gaps, reset).
module tb_rxecrc;

   logic        i_clk = 1'b0;
   logic        i_reset, i_ce, i_en, i_v;
   logic [7:0]  i_d;
   logic        o_v, o_err, o_done;
   logic [7:0]  o_d;
`ifdef RXECRC_ERRCOUNT_EN
   logic [31:0] o_err_count;
`endif

   rxecrc dut (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_ce    (i_ce),
      .i_en    (i_en),
      .i_v     (i_v),
      .i_d     (i_d),
      .o_v     (o_v),
      .o_d     (o_d),
      .o_err   (o_err),
`ifdef RXECRC_ERRCOUNT_EN
      .o_err_count (o_err_count),
`endif
      .o_done  (o_done)
   );

   always #5 i_clk = ~i_clk;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Output monitor: counts only cycles whose preceding edge had i_ce high.
   logic [7:0]  outq[$];
   int          outcyc[$];
   int          cyc = 0;
   logic        ce_seen = 1'b0;
   int          done_cnt = 0;
   logic        last_err = 1'b0;

   always @(posedge i_clk) begin
      cyc     <= cyc + 1;
      ce_seen <= i_ce && !i_reset;
   end

   always @(negedge i_clk) begin
      if (ce_seen && o_v) begin
         outq.push_back(o_d);
         outcyc.push_back(cyc);
      end
      if (ce_seen && o_done) begin
         done_cnt++;
         last_err = o_err;
      end
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic send_frame(input logic en, input logic [7:0] fr[$], input bit gaps,
                             output int first_acc);
      outq.delete();
      outcyc.delete();
      first_acc = -1;
      foreach (fr[k]) begin
         i_ce = 1'b1; i_v = 1'b1; i_d = fr[k]; i_en = en;
         tick();
         if (first_acc < 0) first_acc = cyc;
         if (gaps) begin
            // Frozen cycle with junk data and a flipped mode request.
            i_ce = 1'b0; i_d = 8'h5a; i_en = ~en;
            tick();
         end
      end
      i_ce = 1'b1; i_v = 1'b0; i_en = en;
      tick();
      repeat (3) tick();
   endtask

   task automatic check_bytes(input string tag, input logic [7:0] exp[$]);
      check({tag, "_count"}, outq.size(), exp.size());
      foreach (exp[k]) begin
         if (k < outq.size()) check($sformatf("%s_b%0d", tag, k), outq[k], exp[k]);
      end
   endtask

   logic [7:0] good[$]   = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                             8'h26, 8'h39, 8'hf4, 8'hcb};
   logic [7:0] good_pl[$] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
   logic [7:0] bad[$]    = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h36, 8'h36, 8'h37, 8'h38, 8'h39,
                             8'h26, 8'h39, 8'hf4, 8'hcb};
   logic [7:0] bad_pl[$] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h36, 8'h36, 8'h37, 8'h38, 8'h39};
   logic [7:0] shrt[$]   = '{8'haa, 8'hbb, 8'hcc};
   logic [7:0] none[$];

   initial begin
      int fa, d0;
      i_reset = 1'b1; i_ce = 1'b1; i_en = 1'b1; i_v = 1'b0; i_d = 8'h00;
      repeat (2) tick();
      i_reset = 1'b0;
      check("rst_v", o_v, 1'b0);
      check("rst_d", o_d, 8'h00);
      check("rst_err", o_err, 1'b0);
      check("rst_done", o_done, 1'b0);
`ifdef RXECRC_ERRCOUNT_EN
      check("rst_errcnt", o_err_count, 32'd0);
`endif

      // 1: good frame, strip mode
      d0 = done_cnt;
      send_frame(1'b1, good, 1'b0, fa);
      check_bytes("t1", good_pl);
      if (outcyc.size() > 0) check("t1_latency", outcyc[0] - fa, 4);
      check("t1_done", done_cnt - d0, 1);
      check("t1_err", last_err, 1'b0);
      check("t1_done_clr", o_done, 1'b0);

      // 2: corrupted payload byte
      d0 = done_cnt;
      send_frame(1'b1, bad, 1'b0, fa);
      check_bytes("t2", bad_pl);
      check("t2_done", done_cnt - d0, 1);
      check("t2_err", last_err, 1'b1);

      // 3: runt frame
      d0 = done_cnt;
      send_frame(1'b1, shrt, 1'b0, fa);
      check_bytes("t3", none);
      check("t3_done", done_cnt - d0, 1);
      check("t3_err", last_err, 1'b1);
      check("t3_err_hold", o_err, 1'b1);
`ifdef RXECRC_ERRCOUNT_EN
      check("t3_errcnt", o_err_count, 32'd2);
`endif

      // 6: reset after 6 bytes, then a clean frame
      d0 = done_cnt;
      for (int k = 0; k < 6; k++) begin
         i_ce = 1'b1; i_v = 1'b1; i_en = 1'b1; i_d = good[k];
         tick();
      end
      i_reset = 1'b1;
      tick();
      i_reset = 1'b0; i_v = 1'b0;
      repeat (3) tick();
      check("t6_rst_done", done_cnt - d0, 0);
      check("t6_rst_v", o_v, 1'b0);
      check("t6_rst_err", o_err, 1'b0);
`ifdef RXECRC_ERRCOUNT_EN
      check("t6_rst_errcnt", o_err_count, 32'd0);
`endif
      d0 = done_cnt;
      send_frame(1'b1, good, 1'b0, fa);
      check_bytes("t6", good_pl);
      check("t6_done", done_cnt - d0, 1);
      check("t6_err", last_err, 1'b0);

      // 4: passthrough carries FCS too, one-cycle latency
      d0 = done_cnt;
      send_frame(1'b0, good, 1'b0, fa);
      check_bytes("t4", good);
      if (outcyc.size() > 0) check("t4_latency", outcyc[0] - fa, 0);
      check("t4_done", done_cnt - d0, 1);
      check("t4_err", last_err, 1'b0);

      // 5: i_ce gaps with junk data and i_en flipping mid-frame
      d0 = done_cnt;
      send_frame(1'b1, good, 1'b1, fa);
      check_bytes("t5", good_pl);
      check("t5_done", done_cnt - d0, 1);
      check("t5_err", last_err, 1'b0);
`ifdef RXECRC_ERRCOUNT_EN
      check("end_errcnt", o_err_count, 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
